// File: rtl/dds_sweep_pkg.sv
// dds_sweep_pkg
// Shared types and default widths for the DDS linear frequency sweep
// controller and its dwell timer.
//   sweep_mode_t  : single-shot, sawtooth, triangle (encoding matches cfg_mode)
//   sweep_state_t : controller FSM states
package dds_sweep_pkg;

    localparam int unsigned FTW_W_DEF   = 32;
    localparam int unsigned DWELL_W_DEF = 24;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2
    } sweep_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } sweep_state_t;

    // cfg_mode value 3 is reserved and must be rejected at start.
    function automatic logic mode_valid(input logic [1:0] mode);
        return mode != 2'd3;
    endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer
// Holds each sweep value for H = max(dwell,1) cycles. A load starts a new
// hold period; tick_o is high in the last cycle of that period so the
// controller's update lands exactly H cycles after the previous one.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load_i     : (re)start a hold period with dwell_i
//   clear_i    : stop counting (abort); has priority over load_i
//   dwell_i    : requested dwell in cycles, 0 treated as 1
//   tick_o     : one-cycle expiry indication
module dds_dwell_timer
    import dds_sweep_pkg::*;
#(
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               tick_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] hold;

    always_comb begin
        hold  = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = hold;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    // Zero means idle, so a tick can only follow a load.
    assign tick_o = (cnt_q == DWELL_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller
// Steps the DDS tuning word through a linear sweep from a start to a stop
// tuning word in single-shot, sawtooth or triangle mode.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start, abort        : begin sweep (samples cfg_*), terminate sweep
//   cfg_start_ftw/stop  : sweep bounds, start <= stop
//   cfg_step_ftw        : non-zero increment per step
//   cfg_dwell           : hold cycles per value (0 treated as 1)
//   cfg_mode            : 0 single, 1 sawtooth, 2 triangle, 3 rejected
//   freq_tuning_word    : tuning word to the DDS
//   step_strobe         : pulses whenever freq_tuning_word takes a new value
//   busy, done, cfg_err : status, completion pulse, rejected-start pulse
//   sweep_count         : completed legs/periods since last accepted start
module dds_sweep_controller
    import dds_sweep_pkg::*;
#(
    parameter int unsigned FTW_W   = FTW_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [FTW_W-1:0]   cfg_start_ftw,
    input  logic [FTW_W-1:0]   cfg_stop_ftw,
    input  logic [FTW_W-1:0]   cfg_step_ftw,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    output logic [FTW_W-1:0]   freq_tuning_word,
    output logic               step_strobe,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   sweep_count
);

    sweep_state_t       state_q, state_d;
    sweep_mode_t        mode_q;
    logic [FTW_W-1:0]   start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [FTW_W-1:0]   ftw_q, ftw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               latch_cfg;
    logic               tmr_load, tmr_clear, tmr_tick;
    logic [DWELL_W-1:0] tmr_dwell;
    logic [FTW_W:0]     sum_w, diff_w;
    logic [FTW_W-1:0]   up_next, dn_next;

    // One extra bit so that carry-out reads as "above stop" and borrow
    // reads as "below start"; both then clamp onto the bound.
    always_comb begin
        sum_w   = {1'b0, ftw_q} + {1'b0, step_q};
        diff_w  = {1'b0, ftw_q} - {1'b0, step_q};
        up_next = (sum_w > {1'b0, stop_q}) ? stop_q : sum_w[FTW_W-1:0];
        dn_next = (diff_w[FTW_W] || (diff_w[FTW_W-1:0] < start_q))
                  ? start_q : diff_w[FTW_W-1:0];
    end

    // The first hold period is loaded before the shadow dwell is valid.
    assign tmr_dwell = (state_q == IDLE) ? cfg_dwell : dwell_q;

    dds_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmr_load),
        .clear_i (tmr_clear),
        .dwell_i (tmr_dwell),
        .tick_o  (tmr_tick)
    );

    always_comb begin
        state_d   = state_q;
        ftw_d     = ftw_q;
        cnt_d     = cnt_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        latch_cfg = 1'b0;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((cfg_step_ftw == '0) || (cfg_start_ftw > cfg_stop_ftw) ||
                        !mode_valid(cfg_mode)) begin
                        err_d = 1'b1;
                    end else begin
                        latch_cfg = 1'b1;
                        ftw_d     = cfg_start_ftw;
                        strobe_d  = 1'b1;
                        cnt_d     = '0;
                        state_d   = UP;
                        tmr_load  = 1'b1;
                    end
                end
            end
            UP: begin
                if (abort) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end else if (tmr_tick) begin
                    if (ftw_q != stop_q) begin
                        ftw_d    = up_next;
                        strobe_d = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        case (mode_q)
                            MODE_SAW: begin
                                ftw_d    = start_q;
                                cnt_d    = cnt_q + CNT_W'(1);
                                strobe_d = 1'b1;
                                tmr_load = 1'b1;
                            end
                            MODE_TRI: begin
                                ftw_d    = dn_next;
                                cnt_d    = cnt_q + CNT_W'(1);
                                state_d  = DOWN;
                                strobe_d = 1'b1;
                                tmr_load = 1'b1;
                            end
                            default: begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
            end
            DOWN: begin
                if (abort) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end else if (tmr_tick) begin
                    strobe_d = 1'b1;
                    tmr_load = 1'b1;
                    if (ftw_q != start_q) begin
                        ftw_d = dn_next;
                    end else begin
                        ftw_d   = up_next;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = UP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ftw_q    <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ftw_q    <= ftw_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= MODE_SINGLE;
        end else if (latch_cfg) begin
            start_q <= cfg_start_ftw;
            stop_q  <= cfg_stop_ftw;
            step_q  <= cfg_step_ftw;
            dwell_q <= cfg_dwell;
            mode_q  <= sweep_mode_t'(cfg_mode);
        end
    end

    assign freq_tuning_word = ftw_q;
    assign step_strobe      = strobe_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign cfg_err          = err_q;
    assign sweep_count      = cnt_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
module tb_dds_sweep_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_start_ftw = '0;
    logic [31:0] cfg_stop_ftw = '0;
    logic [31:0] cfg_step_ftw = '0;
    logic [23:0] cfg_dwell = '0;
    logic [1:0]  cfg_mode = '0;
    logic [31:0] freq_tuning_word;
    logic        step_strobe, busy, done, cfg_err;
    logic [15:0] sweep_count;

    dds_sweep_controller #(
        .FTW_W   (32),
        .DWELL_W (24),
        .CNT_W   (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .cfg_start_ftw    (cfg_start_ftw),
        .cfg_stop_ftw     (cfg_stop_ftw),
        .cfg_step_ftw     (cfg_step_ftw),
        .cfg_dwell        (cfg_dwell),
        .cfg_mode         (cfg_mode),
        .freq_tuning_word (freq_tuning_word),
        .step_strobe      (step_strobe),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err),
        .sweep_count      (sweep_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the sweep as a walk over values, each held for H
    // cycles, direction flipping at the bounds.
    longint m_f, m_s, m_e, m_step;
    int     m_h, m_left, m_mode;
    int     m_cnt;
    bit     m_busy, m_up, m_strobe, m_done, m_err;
    longint cyc = 0;
    longint t_acc = 0, t_done = 0;
    bit     done_seen = 0, err_seen = 0;
    longint seq_q[$];
    int     cntseq_q[$];

    function automatic void m_reset();
        m_f = 0; m_busy = 0; m_up = 0; m_strobe = 0; m_done = 0; m_err = 0;
        m_cnt = 0; m_left = 0;
    endfunction

    function automatic void m_advance();
        m_strobe = 1;
        if (m_up) begin
            if (m_f != m_e) begin
                m_f = (m_f + m_step > m_e) ? m_e : m_f + m_step;
            end else if (m_mode == 0) begin
                m_strobe = 0; m_done = 1; m_busy = 0;
            end else if (m_mode == 1) begin
                m_f = m_s; m_cnt = (m_cnt + 1) % 65536;
            end else begin
                m_cnt = (m_cnt + 1) % 65536; m_up = 0;
                m_f = (m_f - m_step < m_s) ? m_s : m_f - m_step;
            end
        end else begin
            if (m_f != m_s) begin
                m_f = (m_f - m_step < m_s) ? m_s : m_f - m_step;
            end else begin
                m_cnt = (m_cnt + 1) % 65536; m_up = 1;
                m_f = (m_f + m_step > m_e) ? m_e : m_f + m_step;
            end
        end
        m_left = m_h;
    endfunction

    function automatic void m_clock();
        m_strobe = 0; m_done = 0; m_err = 0;
        if (!m_busy) begin
            if (start) begin
                if (cfg_step_ftw == 0 || cfg_start_ftw > cfg_stop_ftw || cfg_mode == 3) begin
                    m_err = 1; err_seen = 1;
                end else begin
                    m_s = cfg_start_ftw; m_e = cfg_stop_ftw; m_step = cfg_step_ftw;
                    m_h = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
                    m_mode = cfg_mode;
                    m_f = m_s; m_strobe = 1; m_busy = 1; m_up = 1; m_cnt = 0;
                    m_left = m_h; t_acc = cyc;
                end
            end
        end else if (abort) begin
            m_busy = 0;
        end else begin
            m_left--;
            if (m_left == 0) m_advance();
        end
    endfunction

    // Single compare process: model step at each edge, check outputs 1 ns later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reset();
        end else begin
            cyc++;
            m_clock();
            if (m_strobe) begin
                seq_q.push_back(m_f);
                cntseq_q.push_back(m_cnt);
            end
            if (m_done) begin
                done_seen = 1;
                t_done = cyc;
            end
        end
        #1;
        chk("ftw", freq_tuning_word, m_f);
        chk("strobe", step_strobe, m_strobe);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("cfg_err", cfg_err, m_err);
        chk("sweep_count", sweep_count, m_cnt);
    end

    task automatic launch(input longint s, input longint e, input longint st,
                          input int dw, input int md);
        @(negedge clk);
        cfg_start_ftw = s[31:0]; cfg_stop_ftw = e[31:0]; cfg_step_ftw = st[31:0];
        cfg_dwell = dw[23:0]; cfg_mode = md[1:0];
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic pulse_abort();
        @(negedge clk); abort = 1;
        @(negedge clk); abort = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (m_busy && n < budget) begin @(negedge clk); n++; end
        chk(name, m_busy, 0);
    endtask

    task automatic wait_seq(input string name, input int want, input int budget);
        int n = 0;
        while (seq_q.size() < want && n < budget) begin @(negedge clk); n++; end
        chk(name, seq_q.size() >= want, 1);
    endtask

    task automatic chk_seq(input string name, input longint exp[], input int expc[]);
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s_v%0d", name, i), (i < seq_q.size()) ? seq_q[i] : -1, exp[i]);
            if (expc.size() > 0)
                chk($sformatf("%s_c%0d", name, i), (i < cntseq_q.size()) ? cntseq_q[i] : -1, expc[i]);
        end
    endtask

    function automatic void clear_rec();
        seq_q.delete(); cntseq_q.delete(); done_seen = 0; err_seen = 0;
    endfunction

    initial begin
        longint exp1[] = '{64'h100_0000, 64'h200_0000, 64'h300_0000, 64'h400_0000};
        longint exp2[] = '{64'h100_0000, 64'h280_0000, 64'h400_0000};
        longint exp3[] = '{64'h100_0000, 64'h200_0000, 64'h300_0000, 64'h400_0000,
                           64'h300_0000, 64'h200_0000, 64'h100_0000, 64'h200_0000};
        int     cnt3[] = '{0, 0, 0, 0, 1, 1, 1, 2};
        longint exp4[] = '{64'hFFFF_FF00, 64'hFFFF_FF80, 64'hFFFF_FFFF, 64'hFFFF_FF00};
        int     cnt4[] = '{0, 0, 0, 1};
        int     none[] = '{};
        longint prev;
        logic [1:0] rmode [3] = '{2'd1, 2'd1, 2'd3};
        longint rs [3] = '{64'h10, 64'h5, 64'h10};
        longint rst_ [3] = '{0, 1, 1};

        repeat (3) @(negedge clk);
        chk("reset_ftw", freq_tuning_word, 0);
        chk("reset_busy", busy, 0);
        reset = 0;
        @(negedge clk);

        // Single-shot
        clear_rec();
        launch(64'h100_0000, 64'h400_0000, 64'h100_0000, 4, 0);
        wait_idle("t1_timeout", 200);
        chk_seq("t1", exp1, none);
        chk("t1_done_seen", done_seen, 1);
        chk("t1_done_time", t_done - t_acc, 16);
        @(negedge clk);
        chk("t1_ftw_hold", freq_tuning_word, 64'h400_0000);
        chk("t1_busy", busy, 0);

        // Clamp at stop
        clear_rec();
        launch(64'h100_0000, 64'h400_0000, 64'h180_0000, 4, 0);
        wait_idle("t2_timeout", 200);
        chk_seq("t2", exp2, none);
        chk("t2_len", seq_q.size(), 3);
        chk("t2_done_time", t_done - t_acc, 12);

        // Triangle
        clear_rec();
        launch(64'h100_0000, 64'h400_0000, 64'h100_0000, 2, 2);
        wait_seq("t3_timeout", 8, 100);
        pulse_abort();
        chk_seq("t3", exp3, cnt3);

        // Sawtooth with carry-out at the top of the word
        clear_rec();
        launch(64'hFFFF_FF00, 64'hFFFF_FFFF, 64'h80, 1, 1);
        wait_seq("t4_timeout", 4, 50);
        pulse_abort();
        chk_seq("t4", exp4, cnt4);

        // Rejected starts: step=0, start>stop, mode=3
        for (int i = 0; i < 3; i++) begin
            clear_rec();
            prev = m_f;
            launch(rs[i], 64'h4 + (rs[i] == 64'h10 ? 64'h100 : 0), rst_[i], 1, int'(rmode[i]));
            @(negedge clk);
            chk($sformatf("rej%0d_err", i), err_seen, 1);
            chk($sformatf("rej%0d_busy", i), busy, 0);
            chk($sformatf("rej%0d_ftw", i), freq_tuning_word, prev);
        end

        // Abort during the second dwell
        clear_rec();
        launch(64'h100_0000, 64'h400_0000, 64'h100_0000, 4, 0);
        wait_seq("ab_timeout", 2, 50);
        pulse_abort();
        chk("ab_busy", busy, 0);
        chk("ab_ftw", freq_tuning_word, 64'h200_0000);
        repeat (20) @(negedge clk);
        chk("ab_no_done", done_seen, 0);
        chk("ab_ftw_hold", freq_tuning_word, 64'h200_0000);

        // Asynchronous reset mid-dwell
        launch(64'h100_0000, 64'h400_0000, 64'h100_0000, 4, 0);
        repeat (6) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("arst_ftw", freq_tuning_word, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        reset = 0;

        // start while busy is ignored, cfg changes too
        clear_rec();
        launch(64'h100_0000, 64'h400_0000, 64'h100_0000, 4, 0);
        repeat (3) @(negedge clk);
        launch(64'h10, 64'h20, 64'h1, 0, 1);
        wait_idle("sb_timeout", 200);
        chk_seq("sb", exp1, none);
        chk("sb_done_time", t_done - t_acc, 16);

        // Randomised sweeps, including rejects, mid-sweep start/abort
        for (int n = 0; n < 40; n++) begin
            longint s, e, st, tmp;
            s = $urandom;
            if ($urandom_range(0, 4) == 0) s = 64'hFFFF_F000 + $urandom_range(0, 4095);
            e = s + $urandom_range(0, 4096);
            if (e > 64'hFFFF_FFFF) e = 64'hFFFF_FFFF;
            st = $urandom_range(0, 600);
            if ($urandom_range(0, 9) == 0) begin tmp = s; s = e; e = tmp; end
            launch(s, e, st, $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(5, 60)) begin
                @(negedge clk);
                start = ($urandom_range(0, 9) == 0);
                abort = ($urandom_range(0, 39) == 0);
            end
            @(negedge clk);
            start = 0; abort = 0;
            pulse_abort();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
